// File: rtl/branch_resolve_ctrl.sv
// Branch resolution sequencer around the static predictor: carries decode predictions
// into execute, detects mispredicts, issues redirect/flush and keeps saturating counters.
module branch_resolve_ctrl #(
    parameter int DATA_WIDTH   = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Branch_d,
    input  logic                  predict_taken_d,
    input  logic                  stall_e,
    input  logic                  Branch_e,
    input  logic                  EQ,
    input  logic [DATA_WIDTH-1:0] correct_PC,
    output logic                  pred_redirect,
    output logic                  redirect_valid,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  flush_fd,
    output logic [CNT_WIDTH-1:0]  branch_cnt,
    output logic [CNT_WIDTH-1:0]  mispred_cnt
);

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] FLUSH = 1'b1;

    localparam logic [3:0]           FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    logic [0:0] state;
    logic [3:0] flush_cnt;
    logic       pred_e;
    logic       br_e_valid;
    logic       in_run;
    logic       resolve;
    logic       mispredict;

    assign in_run = (state == RUN);

    // An E-stage mispredict outranks a D-stage predicted-taken redirect in the same cycle.
    always_comb begin
        resolve       = in_run & ~stall_e & Branch_e & br_e_valid;
        mispredict    = resolve & (pred_e != EQ);
        pred_redirect = Branch_d & predict_taken_d & in_run & ~mispredict;
    end

    // The prediction travels alongside the branch through the D->E register; a flush squashes it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_e     <= 1'b0;
            br_e_valid <= 1'b0;
        end else if (!in_run) begin
            pred_e     <= 1'b0;
            br_e_valid <= 1'b0;
        end else if (!stall_e) begin
            pred_e     <= Branch_d & predict_taken_d;
            br_e_valid <= Branch_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= RUN;
            flush_cnt      <= 4'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            flush_fd       <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    redirect_valid <= 1'b0;
                    if (mispredict) begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= correct_PC;
                        flush_fd       <= 1'b1;
                        flush_cnt      <= FLUSH_INIT;
                        state          <= FLUSH;
                    end
                end
                FLUSH: begin
                    // stall_e does not stretch the flush window.
                    redirect_valid <= 1'b0;
                    if (flush_cnt == 4'd0) begin
                        flush_fd <= 1'b0;
                        state    <= RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 4'd1;
                    end
                end
                default: begin
                    state          <= RUN;
                    redirect_valid <= 1'b0;
                    flush_fd       <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            branch_cnt  <= '0;
            mispred_cnt <= '0;
        end else begin
            if (resolve && branch_cnt != CNT_MAX)
                branch_cnt <= branch_cnt + 1'b1;
            if (mispredict && mispred_cnt != CNT_MAX)
                mispred_cnt <= mispred_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed scenarios plus randomized traffic
// checked against an event-level reference model.
module tb_branch_resolve_ctrl;

    localparam int DW  = 32;
    localparam int FC  = 2;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Branch_d, predict_taken_d, stall_e, Branch_e, EQ;
    logic [DW-1:0] correct_PC;
    logic          pred_redirect, redirect_valid, flush_fd;
    logic [DW-1:0] redirect_pc;
    logic [CW-1:0] branch_cnt, mispred_cnt;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: what sits in E, how many flush cycles remain, and the counts.
    int            m_flush_left;
    logic          m_e_pred, m_e_valid;
    logic          m_redirect_valid;
    logic [DW-1:0] m_redirect_pc;
    logic [CW-1:0] m_bcnt, m_mcnt;

    branch_resolve_ctrl #(.DATA_WIDTH(DW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .Branch_d(Branch_d), .predict_taken_d(predict_taken_d), .stall_e(stall_e),
        .Branch_e(Branch_e), .EQ(EQ), .correct_PC(correct_PC),
        .pred_redirect(pred_redirect), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush_fd(flush_fd),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic m_resolve_now();
        return (m_flush_left == 0) && !stall_e && Branch_e && m_e_valid;
    endfunction

    function automatic logic m_mispredict_now();
        return m_resolve_now() && (m_e_pred != EQ);
    endfunction

    function automatic logic m_pred_redirect_now();
        return Branch_d && predict_taken_d && (m_flush_left == 0) && !m_mispredict_now();
    endfunction

    task automatic model_edge();
        logic res, mis;
        if (!rst_n) begin
            m_flush_left = 0; m_e_pred = 0; m_e_valid = 0;
            m_redirect_valid = 0; m_redirect_pc = '0; m_bcnt = '0; m_mcnt = '0;
        end else begin
            res = m_resolve_now();
            mis = m_mispredict_now();
            if (res && m_bcnt != 4'hF) m_bcnt = m_bcnt + 4'd1;
            if (mis && m_mcnt != 4'hF) m_mcnt = m_mcnt + 4'd1;
            if (m_flush_left != 0) begin
                m_e_pred = 0; m_e_valid = 0;
            end else if (!stall_e) begin
                m_e_pred  = Branch_d && predict_taken_d;
                m_e_valid = Branch_d;
            end
            m_redirect_valid = mis;
            if (mis) m_redirect_pc = correct_PC;
            if (mis) m_flush_left = FC;
            else if (m_flush_left > 0) m_flush_left = m_flush_left - 1;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic bd, input logic pt, input logic st,
                          input logic be, input logic eq);
        Branch_d = bd; predict_taken_d = pt; stall_e = st; Branch_e = be; EQ = eq;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        correct_PC = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_in(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            correct_PC = $urandom;
            tick();
            n_compared++;
            if ({redirect_valid, flush_fd, redirect_pc, branch_cnt, mispred_cnt} !== '0) begin
                n_mismatched++;
                $display("[TB] FAIL reset_outputs: got rv=%b ff=%b pc=%h bc=%h mc=%h, required all 0",
                         redirect_valid, flush_fd, redirect_pc, branch_cnt, mispred_cnt);
            end
        end
        rst_n = 1'b1;
        set_in(0, 0, 0, 0, 0);
        tick();
        n_compared++;
        if (branch_cnt !== 4'd0 || mispred_cnt !== 4'd0 || flush_fd !== 1'b0 || pred_redirect !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_release: got bc=%h mc=%h ff=%b pr=%b, required 0 0 0 0",
                     branch_cnt, mispred_cnt, flush_fd, pred_redirect);
        end
    endtask

    task automatic test_correct_not_taken();
        do_reset();
        set_in(1, 0, 0, 0, 0);
        #1;
        n_compared++;
        if (pred_redirect !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL nt_pred_redirect: got %b required 0", pred_redirect);
        end
        tick();
        set_in(0, 0, 0, 1, 0);
        tick();
        n_compared++;
        if (redirect_valid !== 1'b0 || flush_fd !== 1'b0 || branch_cnt !== 4'd1 || mispred_cnt !== 4'd0) begin
            n_mismatched++;
            $display("[TB] FAIL nt_resolve: got rv=%b ff=%b bc=%h mc=%h, required 0 0 1 0",
                     redirect_valid, flush_fd, branch_cnt, mispred_cnt);
        end
    endtask

    task automatic test_mispredict();
        do_reset();
        set_in(1, 1, 0, 0, 0);
        tick();
        set_in(1, 1, 0, 1, 0);
        correct_PC = 32'h0000_0104;
        #1;
        n_compared++;
        if (pred_redirect !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL mis_outranks_pred: got pred_redirect=%b required 0", pred_redirect);
        end
        tick();
        set_in(0, 0, 0, 0, 0);
        correct_PC = 32'hDEAD_BEEF;
        n_compared++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h104 || flush_fd !== 1'b1 || mispred_cnt !== 4'd1) begin
            n_mismatched++;
            $display("[TB] FAIL mis_t1: got rv=%b pc=%h ff=%b mc=%h, required 1 00000104 1 1",
                     redirect_valid, redirect_pc, flush_fd, mispred_cnt);
        end
        tick();
        n_compared++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'h104 || flush_fd !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL mis_t2: got rv=%b pc=%h ff=%b, required 0 00000104 1",
                     redirect_valid, redirect_pc, flush_fd);
        end
        tick();
        n_compared++;
        if (flush_fd !== 1'b0 || redirect_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL mis_t3: got ff=%b rv=%b, required 0 0", flush_fd, redirect_valid);
        end
    endtask

    task automatic test_flush_ignore();
        do_reset();
        set_in(1, 0, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 1);
        tick();
        for (int i = 0; i < FC; i++) begin
            set_in(1, 1, 0, 1, 1);
            #1;
            n_compared++;
            if (pred_redirect !== 1'b0 || flush_fd !== 1'b1) begin
                n_mismatched++;
                $display("[TB] FAIL flush_gate_%0d: got pr=%b ff=%b, required 0 1", i, pred_redirect, flush_fd);
            end
            tick();
        end
        set_in(1, 1, 0, 1, 1);
        #1;
        n_compared++;
        if (pred_redirect !== 1'b1 || branch_cnt !== 4'd1 || mispred_cnt !== 4'd1) begin
            n_mismatched++;
            $display("[TB] FAIL flush_ignored: got pr=%b bc=%h mc=%h, required 1 1 1",
                     pred_redirect, branch_cnt, mispred_cnt);
        end
        set_in(0, 0, 0, 1, 0);
        tick();
        tick();
        n_compared++;
        if (branch_cnt !== 4'd1 || redirect_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL post_flush_invalid_e: got bc=%h rv=%b, required 1 0", branch_cnt, redirect_valid);
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_in(1, 1, 0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 1, 0);
            tick();
            n_compared++;
            if (redirect_valid !== 1'b0 || branch_cnt !== 4'd0 || flush_fd !== 1'b0) begin
                n_mismatched++;
                $display("[TB] FAIL stall_hold_%0d: got rv=%b bc=%h ff=%b, required 0 0 0",
                         i, redirect_valid, branch_cnt, flush_fd);
            end
        end
        set_in(0, 0, 0, 1, 0);
        correct_PC = 32'h0000_2000;
        tick();
        set_in(0, 0, 0, 0, 0);
        n_compared++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h2000 || branch_cnt !== 4'd1 || mispred_cnt !== 4'd1) begin
            n_mismatched++;
            $display("[TB] FAIL stall_release: got rv=%b pc=%h bc=%h mc=%h, required 1 00002000 1 1",
                     redirect_valid, redirect_pc, branch_cnt, mispred_cnt);
        end
        tick();
        tick();
    endtask

    task automatic test_saturation_and_reset();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            set_in(1, 1, 0, 0, 0);
            tick();
            set_in(0, 0, 0, 1, 0);
            correct_PC = DW'(i * 4);
            tick();
            set_in(0, 0, 0, 0, 0);
            for (int k = 0; k < FC; k++) tick();
        end
        n_compared++;
        if (mispred_cnt !== 4'hF || branch_cnt !== 4'hF) begin
            n_mismatched++;
            $display("[TB] FAIL saturate: got mc=%h bc=%h, required f f", mispred_cnt, branch_cnt);
        end
        set_in(1, 1, 0, 0, 0);
        tick();
        set_in(0, 0, 0, 1, 0);
        tick();
        n_compared++;
        if (flush_fd !== 1'b1 || mispred_cnt !== 4'hF) begin
            n_mismatched++;
            $display("[TB] FAIL saturate_enter_flush: got ff=%b mc=%h, required 1 f", flush_fd, mispred_cnt);
        end
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        set_in(1, 1, 0, 0, 0);
        #1;
        n_compared++;
        if (flush_fd !== 1'b0 || redirect_valid !== 1'b0 || branch_cnt !== 4'd0 ||
            mispred_cnt !== 4'd0 || pred_redirect !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL reset_mid_flush: got ff=%b rv=%b bc=%h mc=%h pr=%b, required 0 0 0 0 1",
                     flush_fd, redirect_valid, branch_cnt, mispred_cnt, pred_redirect);
        end
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 99) != 0);
            set_in(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
                   ($urandom_range(0, 3) != 0), 1'($urandom));
            correct_PC = $urandom;
            #1;
            n_compared++;
            if (pred_redirect !== m_pred_redirect_now()) begin
                n_mismatched++;
                $display("[TB] FAIL rand_pred_redirect @%0d: got %b required %b", i, pred_redirect, m_pred_redirect_now());
            end
            tick();
            n_compared++;
            if (redirect_valid !== m_redirect_valid || redirect_pc !== m_redirect_pc ||
                flush_fd !== (m_flush_left > 0) || branch_cnt !== m_bcnt || mispred_cnt !== m_mcnt) begin
                n_mismatched++;
                $display("[TB] FAIL rand_state @%0d: got rv=%b pc=%h ff=%b bc=%h mc=%h, required rv=%b pc=%h ff=%b bc=%h mc=%h",
                         i, redirect_valid, redirect_pc, flush_fd, branch_cnt, mispred_cnt,
                         m_redirect_valid, m_redirect_pc, (m_flush_left > 0), m_bcnt, m_mcnt);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0);
        correct_PC = '0;
        m_flush_left = 0; m_e_pred = 0; m_e_valid = 0;
        m_redirect_valid = 0; m_redirect_pc = '0; m_bcnt = '0; m_mcnt = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_correct_not_taken();
        test_mispredict();
        test_flush_ignore();
        test_stall();
        test_saturation_and_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
